prom_boot_loader: RTL and testbench

Sequencer downstream of the 512x8 bipolar boot PROM model (part_74S472).
- On a start command it walks PROM addresses BASE_ADDR upward.
- It drives address and chip-enable, waits out the PROM access time, and captures each byte.
- It packs BYTES consecutive bytes into one word and hands each word to the control-memory writer over a valid/ready handshake.

---
 rtl/prom_boot_pkg.sv | 20 ++
 rtl/prom_byte_packer.sv | 37 +++
 rtl/prom_boot_loader.sv | 142 ++++++++++++++
 tb/tb_prom_boot_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prom_boot_pkg.sv
// rtl/prom_boot_pkg.sv - shared state encoding and PROM geometry for the boot loader
package prom_boot_pkg;

  localparam int PROM_AW    = 9;
  localparam int PROM_DW    = 8;
  localparam int PROM_DEPTH = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prom_byte_packer.sv
// rtl/prom_byte_packer.sv - lane-addressed byte insert register building one output word
module prom_byte_packer
  import prom_boot_pkg::*;
#(
  parameter int BYTES  = 4,
  parameter int LANE_W = idx_w(BYTES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic [LANE_W-1:0]        lane,
  input  logic [PROM_DW-1:0]       din,
  output logic [PROM_DW*BYTES-1:0] word
);

  logic [PROM_DW*BYTES-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = '0;
    end else begin
      for (int i = 0; i < BYTES; i++) begin
        if (load && lane == LANE_W'(i)) data_d[PROM_DW*i +: PROM_DW] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign word = data_q;

endmodule

// File: rtl/prom_boot_loader.sv
// rtl/prom_boot_loader.sv - walks the boot PROM and emits packed words over valid/ready
module prom_boot_loader
  import prom_boot_pkg::*;
#(
  parameter int BYTES     = 4,
  parameter int READ_WAIT = 2,
  parameter int BASE_ADDR = 0,
  parameter int NUM_WORDS = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [PROM_AW-1:0]       rom_addr,
  output logic                     rom_ce_n,
  input  logic [PROM_DW-1:0]       rom_data,
  output logic [PROM_DW*BYTES-1:0] word_data,
  output logic [PROM_AW-1:0]       word_index,
  output logic                     word_valid,
  input  logic                     word_ready
);

  localparam int WW = idx_w(READ_WAIT);
  localparam int BW = idx_w(BYTES);

  if (BYTES < 1 || BYTES > 6 || READ_WAIT < 1 || NUM_WORDS < 1 || BASE_ADDR < 0 ||
      BASE_ADDR + NUM_WORDS * BYTES > PROM_DEPTH) begin : g_bad_cfg
    $error("prom_boot_loader: illegal BYTES/READ_WAIT/BASE_ADDR/NUM_WORDS combination");
  end

  state_e             state_q, state_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [BW-1:0]      byte_q, byte_d;
  logic [PROM_AW-1:0] addr_q, addr_d;
  logic [PROM_AW-1:0] index_q, index_d;
  logic               ce_n_q, ce_n_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               capture, clear;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    index_d = index_q;
    ce_n_d  = ce_n_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    capture = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        addr_d  = PROM_AW'(BASE_ADDR);
        ce_n_d  = 1'b0;
        byte_d  = '0;
        wait_d  = '0;
        index_d = '0;
        busy_d  = 1'b1;
        clear   = 1'b1;
      end
      READ: begin
        if (wait_q == WW'(READ_WAIT - 1)) begin
          capture = 1'b1;
          addr_d  = addr_q + PROM_AW'(1);
          if (byte_q == BW'(BYTES - 1)) begin
            state_d = EMIT;
            ce_n_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            byte_d = byte_q + BW'(1);
            wait_d = '0;
          end
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      EMIT: if (valid_q && word_ready) begin
        valid_d = 1'b0;
        if (index_q == PROM_AW'(NUM_WORDS - 1)) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = READ;
          index_d = index_q + PROM_AW'(1);
          byte_d  = '0;
          wait_d  = '0;
          ce_n_d  = 1'b0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      byte_q  <= '0;
      addr_q  <= '0;
      index_q <= '0;
      ce_n_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      index_q <= index_d;
      ce_n_q  <= ce_n_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  prom_byte_packer #(.BYTES(BYTES), .LANE_W(BW)) u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .load  (capture),
    .lane  (byte_q),
    .din   (rom_data),
    .word  (word_data)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_addr   = addr_q;
  assign rom_ce_n   = ce_n_q;
  assign word_index = index_q;
  assign word_valid = valid_q;

endmodule

// File: tb/tb_prom_boot_loader.sv
// tb/tb_prom_boot_loader.sv - self-checking bench for prom_boot_loader across four configurations
module tb_prom_boot_loader;

  localparam int NI = 4;
  localparam int CFG_B  [NI] = '{4, 4, 1, 6};
  localparam int CFG_RW [NI] = '{2, 2, 2, 1};
  localparam int CFG_BA [NI] = '{0, 500, 0, 0};
  localparam int CFG_NW [NI] = '{128, 3, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a   [NI];
  logic        start_a [NI];
  logic        ready_a [NI];
  logic        busy_a  [NI];
  logic        done_a  [NI];
  logic        ce_a    [NI];
  logic        valid_a [NI];
  logic [8:0]  addr_a  [NI];
  logic [8:0]  widx_a  [NI];
  logic [47:0] wdata_a [NI];

  // phase: 0 idle, 1 loading, 2 done-pulse cycle; rd = CE-low cycles spent on current word
  int m_phase [NI] = '{0, 0, 0, 0};
  int m_rd    [NI] = '{0, 0, 0, 0};
  int m_k     [NI] = '{0, 0, 0, 0};

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  for (genvar g = 0; g < NI; g++) begin : g_u
    logic [8*CFG_B[g]-1:0] wd;
    logic [7:0]            rdata;
    assign rdata = ce_a[g] ? 8'hE7 : (addr_a[g][7:0] ^ 8'hA5);
    prom_boot_loader #(
      .BYTES(CFG_B[g]), .READ_WAIT(CFG_RW[g]), .BASE_ADDR(CFG_BA[g]), .NUM_WORDS(CFG_NW[g])
    ) u_dut (
      .clk(clk), .reset(rst_a[g]), .start(start_a[g]), .busy(busy_a[g]), .done(done_a[g]),
      .rom_addr(addr_a[g]), .rom_ce_n(ce_a[g]), .rom_data(rdata), .word_data(wd),
      .word_index(widx_a[g]), .word_valid(valid_a[g]), .word_ready(ready_a[g])
    );
    assign wdata_a[g] = 48'(wd);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_a[i]) begin
        m_phase[i] <= 0;
        m_rd[i]    <= 0;
        m_k[i]     <= 0;
      end else if (m_phase[i] == 0) begin
        if (start_a[i]) begin
          m_phase[i] <= 1;
          m_rd[i]    <= 0;
          m_k[i]     <= 0;
        end
      end else if (m_phase[i] == 2) begin
        m_phase[i] <= 0;
      end else if (m_rd[i] < CFG_B[i] * CFG_RW[i]) begin
        m_rd[i] <= m_rd[i] + 1;
      end else if (ready_a[i]) begin
        if (m_k[i] == CFG_NW[i] - 1) begin
          m_phase[i] <= 2;
        end else begin
          m_k[i]  <= m_k[i] + 1;
          m_rd[i] <= 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic monitor();
    bit          rd_on, v_on;
    logic [47:0] exp;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < NI; i++) begin
          rd_on = (m_phase[i] == 1) && (m_rd[i] < CFG_B[i] * CFG_RW[i]);
          v_on  = (m_phase[i] == 1) && (m_rd[i] == CFG_B[i] * CFG_RW[i]);
          chk($sformatf("u%0d_busy", i), 48'(busy_a[i]), 48'(m_phase[i] == 1));
          chk($sformatf("u%0d_done", i), 48'(done_a[i]), 48'(m_phase[i] == 2));
          chk($sformatf("u%0d_rom_ce_n", i), 48'(ce_a[i]), 48'(!rd_on));
          chk($sformatf("u%0d_word_valid", i), 48'(valid_a[i]), 48'(v_on));
          if (rd_on)
            chk($sformatf("u%0d_rom_addr", i), 48'(addr_a[i]),
                48'(CFG_BA[i] + m_k[i] * CFG_B[i] + m_rd[i] / CFG_RW[i]));
          if (v_on) begin
            exp = '0;
            for (int j = 0; j < CFG_B[i]; j++)
              exp[8*j +: 8] = 8'(CFG_BA[i] + m_k[i] * CFG_B[i] + j) ^ 8'hA5;
            chk($sformatf("u%0d_word_data", i), wdata_a[i], exp);
            chk($sformatf("u%0d_word_index", i), 48'(widx_a[i]), 48'(m_k[i]));
          end
        end
      end
    end
  endtask

  // Pulses start on unit i; n = cycles until valid, with the start-sampling edge as cycle 1.
  task automatic first_valid(input int i, output int n);
    start_a[i] = 1'b1;
    step();
    start_a[i] = 1'b0;
    n = 1;
    while (!valid_a[i] && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic finish_load(input int i, output logic [47:0] last, output int acc, output int dn);
    int n;
    int tail;
    n = 0;
    tail = -1;
    acc = 0;
    dn = 0;
    last = '0;
    while (tail != 0 && n < 3000) begin
      if (valid_a[i] && ready_a[i]) begin
        acc++;
        last = wdata_a[i];
      end
      if (done_a[i]) begin
        dn++;
        tail = 3;
      end
      step();
      n++;
      if (tail > 0) tail--;
    end
    chk($sformatf("u%0d_load_finished", i), 48'(n < 3000), 48'd1);
  endtask

  initial begin
    int          n, acc, dn, ndone, first_done, rise_after, prev_done_n, period;
    logic [47:0] last;
    bit          prev_busy;

    for (int i = 0; i < NI; i++) begin
      rst_a[i]   = 1'b1;
      start_a[i] = 1'b0;
      ready_a[i] = 1'b1;
    end
    fork
      monitor();
    join_none
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      chk("reset_rom_ce_n", 48'(ce_a[i]), 48'd1);
      chk("reset_word_valid", 48'(valid_a[i]), 48'd0);
      chk("reset_busy", 48'(busy_a[i]), 48'd0);
      chk("reset_done", 48'(done_a[i]), 48'd0);
      chk("reset_rom_addr", 48'(addr_a[i]), 48'd0);
      chk("reset_word_index", 48'(widx_a[i]), 48'd0);
      chk("reset_word_data", wdata_a[i], 48'd0);
      rst_a[i] = 1'b0;
    end
    chk_on = 1'b1;
    step();

    // full default load
    first_valid(0, n);
    chk("t1_first_valid_cycle", 48'(n), 48'd9);
    chk("t1_word0", wdata_a[0], 48'hA6A7A4A5);
    chk("t1_word0_index", 48'(widx_a[0]), 48'd0);
    finish_load(0, last, acc, dn);
    chk("t1_word127", last, 48'h5A5B5859);
    chk("t1_accepts", 48'(acc), 48'd128);
    chk("t1_done_pulses", 48'(dn), 48'd1);

    // 20-cycle stall on word 5
    first_valid(0, n);
    n = 0;
    while (!(valid_a[0] && widx_a[0] == 9'd5) && n < 200) begin
      step();
      n++;
    end
    ready_a[0] = 1'b0;
    repeat (20) begin
      step();
      chk("t2_stall_word_data", wdata_a[0], 48'hB2B3B0B1);
      chk("t2_stall_rom_ce_n", 48'(ce_a[0]), 48'd1);
    end
    ready_a[0] = 1'b1;
    finish_load(0, last, acc, dn);
    chk("t2_accepts_after_stall", 48'(acc), 48'd123);
    chk("t2_word127", last, 48'h5A5B5859);
    chk("t2_done_pulses", 48'(dn), 48'd1);

    // reset during word 10 byte 2, then restart
    first_valid(0, n);
    n = 0;
    while (widx_a[0] != 9'd10 && n < 2000) begin
      step();
      n++;
    end
    repeat (4) step();
    rst_a[0] = 1'b1;
    step();
    rst_a[0] = 1'b0;
    chk("t4_reset_rom_ce_n", 48'(ce_a[0]), 48'd1);
    chk("t4_reset_word_valid", 48'(valid_a[0]), 48'd0);
    chk("t4_reset_busy", 48'(busy_a[0]), 48'd0);
    dn = 0;
    repeat (20) begin
      step();
      if (done_a[0]) dn++;
    end
    chk("t4_no_done_after_reset", 48'(dn), 48'd0);
    first_valid(0, n);
    chk("t4_restart_valid_cycle", 48'(n), 48'd9);
    chk("t4_restart_word0", wdata_a[0], 48'hA6A7A4A5);
    chk("t4_restart_index", 48'(widx_a[0]), 48'd0);
    finish_load(0, last, acc, dn);
    chk("t4_restart_accepts", 48'(acc), 48'd128);

    // top-of-PROM window 500..511
    first_valid(1, n);
    chk("t3_first_valid_cycle", 48'(n), 48'd9);
    chk("t3_word0", wdata_a[1], 48'h52535051);
    finish_load(1, last, acc, dn);
    chk("t3_last_word", last, 48'h5A5B5859);
    chk("t3_accepts", 48'(acc), 48'd3);
    chk("t3_done_pulses", 48'(dn), 48'd1);

    // start held high: back-to-back loads with one idle cycle between
    start_a[2] = 1'b1;
    prev_busy = 1'b0;
    ndone = 0;
    first_done = -1;
    rise_after = -1;
    prev_done_n = -1;
    period = -1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (done_a[2]) begin
        ndone++;
        if (prev_done_n >= 0 && period < 0) period = k - prev_done_n;
        if (first_done < 0) first_done = k;
        prev_done_n = k;
      end
      if (busy_a[2] && !prev_busy && first_done >= 0 && rise_after < 0) rise_after = k;
      prev_busy = busy_a[2];
    end
    start_a[2] = 1'b0;
    repeat (12) step();
    chk("t5_done_to_busy_gap", 48'(rise_after - first_done), 48'd2);
    chk("t5_load_period", 48'(period), 48'd8);
    chk("t5_multiple_loads", 48'(ndone >= 2), 48'd1);

    // single 48-bit word with READ_WAIT=1
    first_valid(3, n);
    chk("t6_first_valid_cycle", 48'(n), 48'd7);
    chk("t6_word0", wdata_a[3], 48'hA0A1A6A7A4A5);
    finish_load(3, last, acc, dn);
    chk("t6_accepts", 48'(acc), 48'd1);
    chk("t6_done_pulses", 48'(dn), 48'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
